// File: rtl/fifo_ctrl_v3.sv
// Parametrised synchronous FIFO with occupancy count, programmable thresholds,
// selectable show-ahead or registered read, and sticky overflow/underflow flags.
module fifo_ctrl_v3 #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter bit FWFT      = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     enq,
    input  logic                     deq,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int          AW     = $clog2(DEPTH);
    localparam int          PW     = AW + 1;
    localparam logic [31:0] AF_LIM = AF_THRESH;
    localparam logic [31:0] AE_LIM = AE_THRESH;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_en;
    logic             w_rd_en;
    logic [31:0]      w_count_ext;

    // Wrap bits differ with equal addresses means the writer has lapped the reader.
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_wr_en     = enq && !w_full;
    assign w_rd_en     = deq && !w_empty;
    assign w_count_ext = 32'(r_count);

    assign empty        = w_empty;
    assign full         = w_full;
    assign count        = r_count;
    assign almost_full  = (w_count_ext >= AF_LIM);
    assign almost_empty = (w_count_ext <= AE_LIM);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // NOTE: storage has no reset; stale contents are unreachable because empty gates every read.
    always_ff @(posedge clk) begin
        if (w_wr_en && !rst)
            r_mem[r_wr_ptr[AW-1:0]] <= data_in;
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd_en)
                r_rd_ptr <= r_rd_ptr + PW'(1);

            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + PW'(1);
                2'b01:   r_count <= r_count - PW'(1);
                default: r_count <= r_count;
            endcase

            if (enq && w_full)
                r_overflow <= 1'b1;
            else if (clr_err)
                r_overflow <= 1'b0;

            if (deq && w_empty)
                r_underflow <= 1'b1;
            else if (clr_err)
                r_underflow <= 1'b0;
        end
    end

    generate
        if (FWFT) begin : g_show_ahead
            assign data_out   = r_mem[r_rd_ptr[AW-1:0]];
            assign data_valid = !w_empty;
        end else begin : g_registered
            logic [WIDTH-1:0] r_data_out;
            logic             r_data_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_out   <= '0;
                    r_data_valid <= 1'b0;
                end else if (w_rd_en) begin
                    r_data_out   <= r_mem[r_rd_ptr[AW-1:0]];
                    r_data_valid <= 1'b1;
                end else begin
                    r_data_valid <= 1'b0;
                end
            end

            assign data_out   = r_data_out;
            assign data_valid = r_data_valid;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_ctrl_v3.sv
// Directed bench: a show-ahead and a registered-read FIFO driven by the same
// stimulus, each checked against hand-computed expectations.
module tb_fifo_ctrl_v3;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             enq;
    logic             deq;
    logic             clr_err;

    logic [WIDTH-1:0] fw_data_out, rg_data_out;
    logic             fw_valid, rg_valid;
    logic             fw_empty, rg_empty;
    logic             fw_full, rg_full;
    logic             fw_ae, rg_ae;
    logic             fw_af, rg_af;
    logic [CW-1:0]    fw_count, rg_count;
    logic             fw_ovf, rg_ovf;
    logic             fw_unf, rg_unf;

    int checks = 0;
    int errors = 0;

    fifo_ctrl_v3 #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1'b1)
    ) u_fw (
        .clk(clk), .rst(rst), .data_in(data_in), .enq(enq), .deq(deq),
        .clr_err(clr_err), .data_out(fw_data_out), .data_valid(fw_valid),
        .empty(fw_empty), .full(fw_full), .almost_empty(fw_ae),
        .almost_full(fw_af), .count(fw_count), .overflow(fw_ovf),
        .underflow(fw_unf)
    );

    fifo_ctrl_v3 #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1'b0)
    ) u_rg (
        .clk(clk), .rst(rst), .data_in(data_in), .enq(enq), .deq(deq),
        .clr_err(clr_err), .data_out(rg_data_out), .data_valid(rg_valid),
        .empty(rg_empty), .full(rg_full), .almost_empty(rg_ae),
        .almost_full(rg_af), .count(rg_count), .overflow(rg_ovf),
        .underflow(rg_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 ns after the rising edge.
    task automatic cyc(input logic e, input logic d, input logic [WIDTH-1:0] din,
                       input logic clr = 1'b0, input logic r = 1'b0);
        enq     = e;
        deq     = d;
        data_in = din;
        clr_err = clr;
        rst     = r;
        @(posedge clk);
        #1;
        enq     = 1'b0;
        deq     = 1'b0;
        clr_err = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        enq = 0; deq = 0; data_in = '0; clr_err = 0; rst = 0;
        @(negedge clk);

        // Reset state
        cyc(0, 0, 8'h00, 0, 1);
        check("rst_count", fw_count, 0);
        check("rst_empty", fw_empty, 1);
        check("rst_ae", fw_ae, 1);
        check("rst_full", fw_full, 0);
        check("rst_af", fw_af, 0);
        check("rst_ovf", fw_ovf, 0);
        check("rst_unf", fw_unf, 0);
        check("rst_fw_valid", fw_valid, 0);
        check("rst_rg_valid", rg_valid, 0);
        check("rst_rg_data", rg_data_out, 8'h00);

        // First word through an empty FIFO
        cyc(1, 0, 8'hA1);
        check("a1_count", fw_count, 1);
        check("a1_empty", fw_empty, 0);
        check("a1_fw_data", fw_data_out, 8'hA1);
        check("a1_fw_valid", fw_valid, 1);
        check("a1_ae", fw_ae, 1);
        cyc(0, 1, 8'h00);
        check("a1_rg_data", rg_data_out, 8'hA1);
        check("a1_rg_valid", rg_valid, 1);
        check("a1_drained", fw_empty, 1);

        // Fill to full, overflow, then drain in order
        cyc(1, 0, 8'h01);
        cyc(1, 0, 8'h02);
        check("fill2_ae", fw_ae, 0);
        check("fill2_af", fw_af, 0);
        cyc(1, 0, 8'h03);
        check("fill3_af", fw_af, 1);
        check("fill3_full", fw_full, 0);
        cyc(1, 0, 8'h04);
        check("fill4_full", fw_full, 1);
        check("fill4_count", fw_count, 4);
        check("fill4_rg_count", rg_count, 4);
        cyc(1, 0, 8'h05);
        check("ovf_count", fw_count, 4);
        check("ovf_flag", fw_ovf, 1);
        for (int i = 1; i <= 4; i++) begin
            check("drain_fw_data", fw_data_out, i);
            cyc(0, 1, 8'h00);
            check("drain_rg_data", rg_data_out, i);
            check("drain_rg_valid", rg_valid, 1);
        end
        check("drain_empty", fw_empty, 1);
        check("drain_count", fw_count, 0);
        check("ovf_sticky", fw_ovf, 1);

        // Clearing errors
        cyc(0, 0, 8'h00, 1);
        check("clr_ovf", fw_ovf, 0);
        check("clr_rg_ovf", rg_ovf, 0);

        // Wrap: interleaved traffic at count 3, addresses cycle past index 3
        cyc(1, 0, 8'h10);
        cyc(1, 0, 8'h11);
        cyc(1, 0, 8'h12);
        check("wrap_count3", fw_count, 3);
        check("wrap_full3", fw_full, 0);
        for (int k = 0; k < 3; k++) begin
            check("wrap_fw_data", fw_data_out, 8'h10 + k);
            cyc(1, 1, 8'h13 + k);
            check("wrap_rg_data", rg_data_out, 8'h10 + k);
            check("wrap_count", fw_count, 3);
            check("wrap_nofull", fw_full, 0);
        end
        for (int k = 3; k < 6; k++) begin
            check("wrap_tail_fw", fw_data_out, 8'h10 + k);
            cyc(0, 1, 8'h00);
            check("wrap_tail_rg", rg_data_out, 8'h10 + k);
        end
        check("wrap_empty", fw_empty, 1);

        // Full with simultaneous enq/deq: read wins, write dropped
        for (int k = 0; k < 4; k++) cyc(1, 0, 8'h21 + k);
        check("full_again", fw_full, 1);
        cyc(1, 1, 8'h55);
        check("fd_count", fw_count, 3);
        check("fd_ovf", fw_ovf, 1);
        check("fd_rg_data", rg_data_out, 8'h21);
        for (int k = 1; k < 4; k++) begin
            check("fd_rest_fw", fw_data_out, 8'h21 + k);
            cyc(0, 1, 8'h00);
        end
        check("fd_empty", fw_empty, 1);
        check("fd_unf_clear", fw_unf, 0);

        // Empty with simultaneous enq/deq: write wins, read ignored
        cyc(1, 1, 8'h66);
        check("ed_count", fw_count, 1);
        check("ed_unf", fw_unf, 1);
        check("ed_fw_data", fw_data_out, 8'h66);
        check("ed_rg_valid", rg_valid, 0);
        cyc(0, 1, 8'h00);
        check("ed_rg_data", rg_data_out, 8'h66);

        // clr_err coinciding with a new underflow: set wins
        cyc(0, 1, 8'h00, 1);
        check("setwins_unf", fw_unf, 1);
        check("setwins_ovf", fw_ovf, 0);
        cyc(0, 0, 8'h00, 1);
        check("clr_unf", fw_unf, 0);

        // Registered read latency and valid pulse
        cyc(1, 0, 8'h11);
        cyc(1, 0, 8'h22);
        check("rg_idle_valid", rg_valid, 0);
        cyc(0, 1, 8'h00);
        check("rg_n1_data", rg_data_out, 8'h11);
        check("rg_n1_valid", rg_valid, 1);
        cyc(0, 0, 8'h00);
        check("rg_n2_valid", rg_valid, 0);
        check("rg_n2_hold", rg_data_out, 8'h11);
        cyc(0, 1, 8'h00);
        check("rg_second", rg_data_out, 8'h22);

        // Reset mid-operation discards contents and ignores same-cycle traffic
        cyc(1, 0, 8'h31);
        cyc(1, 0, 8'h32);
        cyc(1, 0, 8'h33);
        check("pre_rst_count", fw_count, 3);
        cyc(1, 1, 8'h77, 0, 1);
        check("mid_rst_count", fw_count, 0);
        check("mid_rst_empty", fw_empty, 1);
        check("mid_rst_fw_valid", fw_valid, 0);
        check("mid_rst_rg_valid", rg_valid, 0);
        check("mid_rst_rg_data", rg_data_out, 8'h00);
        cyc(0, 1, 8'h00);
        check("post_rst_rg_valid", rg_valid, 0);
        check("post_rst_unf", rg_unf, 1);
        cyc(1, 0, 8'h44);
        check("post_rst_fw_data", fw_data_out, 8'h44);
        cyc(0, 1, 8'h00);
        check("post_rst_rg_data", rg_data_out, 8'h44);
        check("post_rst_empty", rg_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl_v3.md
Name: fifo_ctrl_v3

Overview:
- Parametrised synchronous FIFO, next generation of the system-bus buffer.
- Adds correct full detection and a true occupancy count.
- Adds programmable almost-full and almost-empty thresholds, and a selectable read mode: show-ahead (FWFT) or registered.
- Adds sticky overflow/underflow error flags.
- Sits between bus masters/slaves and arbitration logic as the standard elastic buffer.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 16, number of entries; must be a power of 2 and >= 2.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.
- FWFT, 1, 1 = show-ahead read; 0 = registered read with 1-cycle latency.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- data_in  in  WIDTH  write data.
- enq  in  1  write request.
- deq  in  1  read request.
- clr_err  in  1  clears the sticky error flags.
- data_out  out  WIDTH  read data.
- data_valid  out  1  data_out holds a valid word.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_THRESH.
- almost_full  out  1  count >= AF_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: enq seen while full.
- underflow  out  1  sticky: deq seen while empty.

Behaviour:
- Reset (rst high at a clock edge):
  - rd_ptr = wr_ptr = 0, count = 0.
  - empty = 1, almost_empty = 1; full = 0, almost_full = 0.
  - overflow = underflow = 0, data_valid = 0.
  - data_out = 0 in registered mode.
  - Memory contents are not reset.
  - Reset mid-operation discards all entries; same-cycle enq/deq are ignored.
- Pointers:
  - $clog2(DEPTH)+1 bits each; the low bits address memory, the MSB is a wrap bit.
  - Both wrap naturally modulo 2*DEPTH.
  - full is true when the MSBs differ and the low bits are equal; empty is true when the pointers are equal.
- Accepted write = enq && !full:
  - mem[wr_ptr] <= data_in; wr_ptr increments.
- Accepted read = deq && !empty:
  - rd_ptr increments.
- Full/empty evaluation:
  - full and empty use the state before the edge.
  - enq while full is dropped even if deq is accepted in the same cycle.
  - deq while empty is ignored even if enq is accepted in the same cycle.
- count update:
  - +1 on write only, -1 on read only, unchanged when both are accepted.
  - All flags are combinational from count/pointers, so they update the cycle after the edge.
- FWFT = 1:
  - data_out = mem[rd_ptr] combinationally; data_valid = !empty.
  - A word written into an empty FIFO appears on data_out the cycle after its write edge.
- FWFT = 0:
  - On an accepted read, data_out <= mem[rd_ptr] and data_valid <= 1; otherwise data_valid <= 0 and data_out holds its value.
  - Read latency is 1 cycle from the deq edge.
- Errors:
  - overflow <= 1 on enq && full; underflow <= 1 on deq && empty.
  - Both stay set until clr_err or rst.
  - If clr_err coincides with a new error event, the flag stays set (set wins).
- Thresholds:
  - Compared against count as unsigned values.
  - AF_THRESH > DEPTH means almost_full never asserts.
  - AE_THRESH = 0 means almost_empty equals empty.
- No combinational path exists from enq/deq to full/empty/count.

Test Plan (WIDTH=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1 unless noted):
- FWFT=1, reset, then enq 0xA1 -> next cycle count=1, empty=0, data_out=0xA1, data_valid=1, almost_empty=1.
- Enq 0x01..0x04 -> after 3rd write almost_full=1; after 4th write full=1, count=4. Then enq 0x05 -> dropped, overflow=1, count=4. Drain 4 words -> 0x01,0x02,0x03,0x04 in order, then empty=1.
- Wrap: enq 6 words and deq interleaved so pointers pass index 3 twice -> output order matches input, full never falsely asserted at count=3.
- Full with simultaneous enq 0x55 and deq -> read accepted, write dropped, count=3, overflow=1. Empty with simultaneous enq 0x66 and deq -> write accepted, count=1, underflow=1.
- FWFT=0: enq 0x11, 0x22, then deq on cycle N -> data_out=0x11, data_valid=1 at cycle N+1; data_valid=0 at N+2 with no deq.
- clr_err with overflow=1 -> overflow=0 next cycle. rst asserted with count=3 -> count=0, empty=1, and prior data is never output.
